bluetooth_tx: RTL and testbench

BLUETOOTH_TX -- requirements
Module: bluetooth_tx

---
 rtl/bt_pkg.sv | 38 +++
 rtl/uart_byte_tx.sv | 95 +++++++++
 rtl/bluetooth_tx.sv | 108 ++++++++++
 tb/tb_bluetooth_tx.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bt_pkg.sv
// ============================================================================
// Module  : bt_pkg
// Brief   : Shared frame constants, FSM state type and helpers for bluetooth_tx.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

package bt_pkg;

    localparam logic [7:0] FRAME_HDR   = 8'hA5;
    localparam int         FRAME_BYTES = 5;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } bt_state_e;

    function automatic int bt_div(input int clk_hz, input int baud);
        return clk_hz / baud;
    endfunction

    // Bytes 1..4 of a frame packed LSB-first: {checksum, score_lo, score_hi, level}.
    function automatic logic [31:0] bt_payload(input logic [13:0] score,
                                               input logic [7:0]  level);
        logic [7:0] hi;
        logic [7:0] lo;
        logic [7:0] csum;
        hi   = {2'b00, score[13:8]};
        lo   = score[7:0];
        csum = FRAME_HDR ^ level ^ hi ^ lo;
        return {csum, lo, hi, level};
    endfunction

endpackage

`default_nettype wire

// File: rtl/uart_byte_tx.sv
// ============================================================================
// Module  : uart_byte_tx
// Brief   : 8N1 serializer for one byte; a load at stop-bit end chains the next byte.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_byte_tx
    import bt_pkg::*;
#(
    parameter int DIV = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [7:0] data,
    output logic       tx,
    output logic       byte_done
);

    localparam int            CW     = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] C_LAST = CW'(DIV - 1);

    bt_state_e     r_state;
    logic [CW-1:0] r_cnt;
    logic [2:0]    r_bit;
    logic [7:0]    r_data;
    logic          r_tx;
    logic          w_bit_end;
    logic [2:0]    w_bit_nxt;

    assign w_bit_end = (r_cnt == C_LAST);
    assign w_bit_nxt = r_bit + 3'd1;
    // Asserted during the last cycle of a stop bit, so the owner can chain a byte gaplessly.
    assign byte_done = (r_state == ST_STOP) && w_bit_end;
    assign tx        = r_tx;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_bit   <= '0;
            r_data  <= '0;
            r_tx    <= 1'b1;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (load) begin
                        r_state <= ST_START;
                        r_data  <= data;
                        r_cnt   <= '0;
                        r_bit   <= '0;
                        r_tx    <= 1'b0;
                    end
                end
                default: begin
                    if (!w_bit_end) begin
                        r_cnt <= r_cnt + 1'b1;
                    end else begin
                        r_cnt <= '0;
                        case (r_state)
                            ST_START: begin
                                r_state <= ST_DATA;
                                r_tx    <= r_data[0];
                            end
                            ST_DATA: begin
                                if (r_bit == 3'd7) begin
                                    r_state <= ST_STOP;
                                    r_tx    <= 1'b1;
                                end else begin
                                    r_bit <= w_bit_nxt;
                                    r_tx  <= r_data[w_bit_nxt];
                                end
                            end
                            default: begin
                                if (load) begin
                                    r_state <= ST_START;
                                    r_data  <= data;
                                    r_bit   <= '0;
                                    r_tx    <= 1'b0;
                                end else begin
                                    r_state <= ST_IDLE;
                                    r_tx    <= 1'b1;
                                end
                            end
                        endcase
                    end
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/bluetooth_tx.sv
// ============================================================================
// Module  : bluetooth_tx
// Brief   : Sends 5-byte score/level status frames over UART with one-deep queuing.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

module bluetooth_tx
    import bt_pkg::*;
#(
    parameter int CLK_HZ = 25_175_000,
    parameter int BAUD   = 9600
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        send,
    input  logic [13:0] score,
    input  logic [7:0]  game_level,
    output logic        tx,
    output logic        busy,
    output logic        done
);

    localparam int DIV = bt_div(CLK_HZ, BAUD);

    logic [2:0]  r_byte_idx;
    logic [31:0] r_payload;
    logic        r_pend;
    logic [13:0] r_pend_score;
    logic [7:0]  r_pend_level;
    logic        r_busy;
    logic        r_done;

    logic        w_byte_done;
    logic        w_accept;
    logic        w_last;
    logic        w_send_busy;
    logic        w_have_pend;
    logic        w_load;
    logic [7:0]  w_load_data;
    logic [13:0] w_next_score;
    logic [7:0]  w_next_level;

    assign w_accept     = send && !r_busy;
    assign w_send_busy  = send && r_busy;
    assign w_last       = w_byte_done && (r_byte_idx == 3'(FRAME_BYTES - 1));
    // A send landing on the final stop-bit edge still counts as pending.
    assign w_have_pend  = r_pend || w_send_busy;
    assign w_next_score = w_send_busy ? score      : r_pend_score;
    assign w_next_level = w_send_busy ? game_level : r_pend_level;
    assign w_load       = w_accept || (w_byte_done && (!w_last || w_have_pend));
    assign w_load_data  = (w_byte_done && !w_last) ? r_payload[7:0] : FRAME_HDR;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_byte_idx   <= '0;
            r_payload    <= '0;
            r_pend       <= 1'b0;
            r_pend_score <= '0;
            r_pend_level <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_accept) begin
                r_payload  <= bt_payload(score, game_level);
                r_byte_idx <= '0;
                r_busy     <= 1'b1;
            end else if (w_byte_done) begin
                if (!w_last) begin
                    r_byte_idx <= r_byte_idx + 3'd1;
                    r_payload  <= r_payload >> 8;
                end else begin
                    r_done     <= 1'b1;
                    r_byte_idx <= '0;
                    if (w_have_pend) begin
                        r_payload <= bt_payload(w_next_score, w_next_level);
                        r_pend    <= 1'b0;
                    end else begin
                        r_busy <= 1'b0;
                    end
                end
            end
            if (w_send_busy && !w_last) begin
                r_pend       <= 1'b1;
                r_pend_score <= score;
                r_pend_level <= game_level;
            end
        end
    end

    uart_byte_tx #(
        .DIV (DIV)
    ) u_byte_tx (
        .clk       (clk),
        .rst       (rst),
        .load      (w_load),
        .data      (w_load_data),
        .tx        (tx),
        .byte_done (w_byte_done)
    );

    assign busy = r_busy;
    assign done = r_done;

endmodule

`default_nettype wire

// File: tb/tb_bluetooth_tx.sv
// ============================================================================
// Module  : tb_bluetooth_tx
// Brief   : Self-checking bench for bluetooth_tx against a frame-level reference model.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bluetooth_tx;

    localparam int BITC  = 16;
    localparam int BYTEC = 10 * BITC;
    localparam int FRMC  = 5 * BYTEC;
    localparam int MAXC  = 2000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        send = 1'b0;
    logic [13:0] score = '0;
    logic [7:0]  game_level = '0;
    logic        tx;
    logic        busy;
    logic        done;

    int n_cmp = 0;
    int n_bad = 0;

    logic        s_send  [MAXC];
    logic [13:0] s_score [MAXC];
    logic [7:0]  s_level [MAXC];
    logic        g_tx [MAXC], g_busy [MAXC], g_done [MAXC];
    logic        e_tx [MAXC], e_busy [MAXC], e_done [MAXC];
    int          m_start [$];
    logic [39:0] m_frame [$];

    bluetooth_tx #(.CLK_HZ(16), .BAUD(1)) dut (
        .clk(clk), .rst(rst), .send(send), .score(score),
        .game_level(game_level), .tx(tx), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // Frame bytes straight from the frame definition: byte k is f[8k +: 8].
    function automatic logic [39:0] ref_frame(input logic [13:0] s, input logic [7:0] l);
        int hi, lo, ck;
        hi = int'(s) / 256;
        lo = int'(s) % 256;
        ck = 'hA5 ^ int'(l) ^ hi ^ lo;
        return {8'(ck), 8'(lo), 8'(hi), l, 8'hA5};
    endfunction

    function automatic void paint(input int s, input logic [39:0] f, input int n);
        for (int k = 0; k < 5; k++) begin
            for (int j = 0; j < 10; j++) begin
                logic v;
                v = (j == 0) ? 1'b0 : (j == 9) ? 1'b1 : f[8*k + j - 1];
                for (int t = 0; t < BITC; t++) begin
                    int idx;
                    idx = s + k*BYTEC + j*BITC + t;
                    if (idx < n) e_tx[idx] = v;
                end
            end
        end
        for (int t = 0; t < FRMC; t++) if (s + t < n) e_busy[s + t] = 1'b1;
        if (s + FRMC < n) e_done[s + FRMC] = 1'b1;
    endfunction

    function automatic void start_frame(input int c, input logic [13:0] sc, input logic [7:0] lv, input int n);
        m_start.push_back(c);
        m_frame.push_back(ref_frame(sc, lv));
        paint(c, ref_frame(sc, lv), n);
    endfunction

    // Frame-level model: a frame runs FRMC cycles; sends during a frame keep only the latest.
    function automatic void run_model(input int n);
        bit          active, pend;
        int          fend;
        logic [13:0] ps;
        logic [7:0]  pl;
        active = 0; pend = 0; fend = 0; ps = '0; pl = '0;
        m_start.delete();
        m_frame.delete();
        for (int i = 0; i < n; i++) begin
            e_tx[i] = 1'b1; e_busy[i] = 1'b0; e_done[i] = 1'b0;
        end
        for (int c = 0; c < n; c++) begin
            if (active && c == fend) begin
                if (s_send[c]) begin
                    start_frame(c, s_score[c], s_level[c], n); fend = c + FRMC; pend = 0;
                end else if (pend) begin
                    start_frame(c, ps, pl, n); fend = c + FRMC; pend = 0;
                end else begin
                    active = 0;
                end
            end else if (active && s_send[c]) begin
                pend = 1; ps = s_score[c]; pl = s_level[c];
            end else if (!active && s_send[c]) begin
                start_frame(c, s_score[c], s_level[c], n); fend = c + FRMC; active = 1;
            end
        end
    endfunction

    function automatic int first_diff(input int n);
        for (int i = 0; i < n; i++)
            if (g_tx[i] !== e_tx[i] || g_busy[i] !== e_busy[i] || g_done[i] !== e_done[i]) return i;
        return -1;
    endfunction

    function automatic int count_busy(input int n);
        int k;
        k = 0;
        for (int i = 0; i < n; i++) if (g_busy[i] === 1'b1) k++;
        return k;
    endfunction

    function automatic int count_done(input int n);
        int k;
        k = 0;
        for (int i = 0; i < n; i++) if (g_done[i] === 1'b1) k++;
        return k;
    endfunction

    // UART receiver view: sample each data bit in the middle of its period.
    function automatic logic [7:0] decode(input int s, input int k);
        logic [7:0] b;
        for (int j = 0; j < 8; j++) b[j] = g_tx[s + k*BYTEC + BITC + j*BITC + BITC/2];
        return b;
    endfunction

    task automatic clear_sched(input int n, input bit jitter, input logic [13:0] sc, input logic [7:0] lv);
        for (int c = 0; c < n; c++) begin
            s_send[c]  = 1'b0;
            s_score[c] = jitter ? 14'($urandom) : sc;
            s_level[c] = jitter ? 8'($urandom)  : lv;
        end
    endtask

    task automatic capture(input int n);
        for (int c = 0; c < n; c++) begin
            send = s_send[c]; score = s_score[c]; game_level = s_level[c];
            @(posedge clk); #1;
            g_tx[c] = tx; g_busy[c] = busy; g_done[c] = done;
        end
        send = 1'b0;
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while (busy === 1'b1 && k < 3000) begin @(posedge clk); #1; k++; end
        n_cmp++;
        if (busy !== 1'b0) begin
            n_bad++; $display("FAIL wait_idle: busy=%0b after %0d cycles, required 0", busy, k);
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        bit ok;
        #2 rst = 1'b0;
        #10;
        n_cmp++; if (tx !== 1'b1)   begin n_bad++; $display("FAIL reset_tx: got %0b required 1", tx); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %0b required 0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %0b required 0", done); end
        @(posedge clk); #1;
        rst = 1'b1;
        ok = 1;
        repeat (20) begin @(posedge clk); #1; if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0) ok = 0; end
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL post_reset_idle: line not idle, required tx=1 busy=0 done=0"); end
    endtask

    task automatic test_frame(input string name, input logic [13:0] sc, input logic [7:0] lv, input logic [39:0] want);
        int n, d;
        n = 900;
        clear_sched(n, 0, sc, lv);
        s_send[2] = 1'b1;
        run_model(n);
        capture(n);
        d = first_diff(n);
        n_cmp++;
        if (d >= 0) begin
            n_bad++;
            $display("FAIL %s trace: cycle %0d got tx/busy/done=%0b%0b%0b required %0b%0b%0b",
                     name, d, g_tx[d], g_busy[d], g_done[d], e_tx[d], e_busy[d], e_done[d]);
        end
        for (int k = 0; k < 5; k++) begin
            n_cmp++;
            if (decode(2, k) !== want[8*k +: 8]) begin
                n_bad++; $display("FAIL %s byte%0d: got %02h required %02h", name, k, decode(2, k), want[8*k +: 8]);
            end
        end
        n_cmp++;
        if (count_busy(n) != FRMC) begin n_bad++; $display("FAIL %s busy_len: got %0d required %0d", name, count_busy(n), FRMC); end
        n_cmp++;
        if (count_done(n) != 1 || g_done[2 + FRMC] !== 1'b1) begin
            n_bad++; $display("FAIL %s done_pulse: got count %0d at-end %0b required 1 1", name, count_done(n), g_done[2 + FRMC]);
        end
    endtask

    task automatic test_back_to_back();
        int n, d;
        n = 1700;
        clear_sched(n, 0, 14'd1, 8'h11);
        s_send[0] = 1'b1; s_score[0] = 14'd1;
        s_send[100] = 1'b1; s_score[100] = 14'd2;
        s_send[200] = 1'b1; s_score[200] = 14'd3;
        run_model(n);
        capture(n);
        d = first_diff(n);
        n_cmp++;
        if (d >= 0) begin
            n_bad++;
            $display("FAIL b2b trace: cycle %0d got tx/busy/done=%0b%0b%0b required %0b%0b%0b",
                     d, g_tx[d], g_busy[d], g_done[d], e_tx[d], e_busy[d], e_done[d]);
        end
        n_cmp++; if (count_done(n) != 2) begin n_bad++; $display("FAIL b2b done_count: got %0d required 2", count_done(n)); end
        n_cmp++; if (count_busy(n) != 2*FRMC) begin n_bad++; $display("FAIL b2b busy_len: got %0d required %0d", count_busy(n), 2*FRMC); end
        n_cmp++; if (decode(FRMC, 3) !== 8'h03) begin n_bad++; $display("FAIL b2b second_score_lo: got %02h required 03", decode(FRMC, 3)); end
        n_cmp++; if (decode(FRMC, 2) !== 8'h00) begin n_bad++; $display("FAIL b2b second_score_hi: got %02h required 00", decode(FRMC, 2)); end
    endtask

    task automatic test_reset_mid_frame();
        int n, d;
        bit ok;
        n = 300;
        clear_sched(n, 0, 14'd500, 8'h07);
        s_send[0] = 1'b1;
        run_model(n);
        capture(n);
        d = first_diff(n);
        n_cmp++;
        if (d >= 0) begin n_bad++; $display("FAIL abort partial_trace: cycle %0d got tx=%0b required %0b", d, g_tx[d], e_tx[d]); end
        #2 rst = 1'b0;
        #1;
        n_cmp++; if (tx !== 1'b1)   begin n_bad++; $display("FAIL abort_tx: got %0b required 1", tx); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL abort_busy: got %0b required 0", busy); end
        ok = 1;
        repeat (3) begin @(posedge clk); #1; if (done !== 1'b0 || tx !== 1'b1) ok = 0; end
        rst = 1'b1;
        repeat (30) begin @(posedge clk); #1; if (done !== 1'b0 || tx !== 1'b1 || busy !== 1'b0) ok = 0; end
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL abort_quiet: activity seen after abort, required idle"); end
        n = 850;
        clear_sched(n, 0, 14'($urandom), 8'($urandom));
        s_send[4] = 1'b1;
        run_model(n);
        capture(n);
        d = first_diff(n);
        n_cmp++;
        if (d >= 0) begin
            n_bad++;
            $display("FAIL abort next_frame: cycle %0d got tx/busy/done=%0b%0b%0b required %0b%0b%0b",
                     d, g_tx[d], g_busy[d], g_done[d], e_tx[d], e_busy[d], e_done[d]);
        end
    endtask

    task automatic test_snapshot();
        int n, d;
        n = 1700;
        clear_sched(n, 1, '0, '0);
        s_send[3] = 1'b1;
        s_send[3 + FRMC + 1] = 1'b1;
        run_model(n);
        capture(n);
        d = first_diff(n);
        n_cmp++;
        if (d >= 0) begin
            n_bad++;
            $display("FAIL snapshot trace: cycle %0d got tx/busy/done=%0b%0b%0b required %0b%0b%0b",
                     d, g_tx[d], g_busy[d], g_done[d], e_tx[d], e_busy[d], e_done[d]);
        end
        for (int k = 1; k < 5; k++) begin
            logic [39:0] f;
            f = ref_frame(s_score[3], s_level[3]);
            n_cmp++;
            if (decode(3, k) !== f[8*k +: 8]) begin
                n_bad++; $display("FAIL snapshot byte%0d: got %02h required %02h", k, decode(3, k), f[8*k +: 8]);
            end
        end
        n_cmp++;
        if (g_done[3 + FRMC] !== 1'b1 || g_tx[3 + FRMC + 1] !== 1'b0) begin
            n_bad++; $display("FAIL send_on_done: got done=%0b next_tx=%0b required 1 0", g_done[3 + FRMC], g_tx[3 + FRMC + 1]);
        end
    endtask

    task automatic test_random();
        for (int it = 0; it < 3; it++) begin
            int n, d, ns, nd;
            n = 1900;
            clear_sched(n, 1, '0, '0);
            ns = int'($urandom_range(1, 6));
            for (int k = 0; k < ns; k++) s_send[$urandom_range(0, 1200)] = 1'b1;
            run_model(n);
            capture(n);
            d = first_diff(n);
            n_cmp++;
            if (d >= 0) begin
                n_bad++;
                $display("FAIL random%0d trace: cycle %0d got tx/busy/done=%0b%0b%0b required %0b%0b%0b",
                         it, d, g_tx[d], g_busy[d], g_done[d], e_tx[d], e_busy[d], e_done[d]);
            end
            nd = 0;
            foreach (m_start[i]) if (m_start[i] + FRMC < n) nd++;
            n_cmp++;
            if (count_done(n) != nd) begin n_bad++; $display("FAIL random%0d done_count: got %0d required %0d", it, count_done(n), nd); end
            wait_idle();
        end
    endtask

    initial begin
        test_reset();
        test_frame("basic", 14'd1234, 8'h03, 40'h70_D2_04_03_A5);
        wait_idle();
        test_frame("max_score", 14'd16383, 8'hFF, 40'h9A_FF_3F_FF_A5);
        wait_idle();
        test_back_to_back();
        wait_idle();
        test_reset_mid_frame();
        wait_idle();
        test_snapshot();
        wait_idle();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
